// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency req/ack port and feeds IF/ID.
// Optional performance counters are built in when STAGE_IF_PERF_EN is defined.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        inst_valid
`ifdef STAGE_IF_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_req_addr;
    logic [31:0] w_req_addr_next;
    logic [31:0] r_buf;
    logic [31:0] w_buf_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic        w_consume;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = {branch_addr[31:2], 2'b00};

    // Outputs are forced to their idle values while rst is high, whatever state is held.
    assign imem_req   = ((r_state == FETCH) || (r_state == DROP)) && !rst;
    assign imem_addr  = r_req_addr;
    assign inst_valid = (((r_state == FETCH) && imem_ack) || (r_state == HOLD))
                        && !branch_taken && !rst;
    assign pc_out     = rst ? (RESET_PC + 32'd4) : w_pc_plus4;
    assign w_consume  = inst_valid && !freeze;

    always_comb begin
        instruction_out = NOP_INST;
        if (inst_valid) begin
            instruction_out = (r_state == HOLD) ? r_buf : imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf      <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_addr_next;
            r_buf      <= w_buf_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_addr_next = r_req_addr;
        w_buf_next      = r_buf;
        if (branch_taken) begin
            // Redirect wins over freeze; an outstanding request must still be acked
            // before the new target can be presented, hence DROP.
            w_pc_next = w_branch_target;
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        w_req_addr_next = w_branch_target;
                        w_state_next    = FETCH;
                    end else begin
                        w_state_next = DROP;
                    end
                end
                HOLD: begin
                    w_req_addr_next = w_branch_target;
                    w_state_next    = FETCH;
                end
                DROP: begin
                    if (imem_ack) begin
                        w_req_addr_next = w_branch_target;
                        w_state_next    = FETCH;
                    end
                end
                default: w_state_next = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        if (!freeze) begin
                            w_pc_next       = w_pc_plus4;
                            w_req_addr_next = w_pc_plus4;
                        end else begin
                            w_buf_next   = imem_rdata;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        w_pc_next       = w_pc_plus4;
                        w_req_addr_next = w_pc_plus4;
                        w_state_next    = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        w_req_addr_next = r_pc;
                        w_state_next    = FETCH;
                    end
                end
                default: w_state_next = FETCH;
            endcase
        end
    end

`ifdef STAGE_IF_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_consume) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (imem_req && !imem_ack) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    logic w_unused_consume;
    assign w_unused_consume = w_consume;
`endif

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: consumed words are checked by a scoreboard monitor,
// handshake/PC details by per-cycle checks in the stimulus process.
module tb_stage_if;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        inst_valid;
`ifdef STAGE_IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    stage_if dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .inst_valid      (inst_valid)
`ifdef STAGE_IF_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every consumed word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && inst_valid === 1'b1 && freeze === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL consume_unexpected: got pc 0x%08h inst 0x%08h expected none",
                         pc_out, instruction_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc_out !== e.pc || instruction_out !== e.inst) begin
                    n_fails++;
                    $display("FAIL consume: got pc 0x%08h inst 0x%08h expected pc 0x%08h inst 0x%08h",
                             pc_out, instruction_out, e.pc, e.inst);
                end else begin
                    $display("ok   consume: pc 0x%08h inst 0x%08h", pc_out, instruction_out);
                end
            end
        end
    end

    task automatic drive(input logic f, input logic b, input logic [31:0] ba,
                         input logic a, input logic [31:0] rd);
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ack     = a;
        imem_rdata   = rd;
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_instruction", instruction_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd4);
        next_cycle();
        rst = 1'b0;
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        next_cycle();

        // Zero-wait memory: one instruction per cycle.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h100 + n);
            expect_word(32'd4 * (n + 1), 32'h100 + n);
            @(negedge clk);
            chk("zw_imem_addr", imem_addr, 32'd4 * n);
            chk("zw_inst_valid", {31'd0, inst_valid}, 32'd1);
            next_cycle();
        end

        // Three-cycle latency.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            if (n == 2) begin
                drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0000);
                expect_word(32'd4, 32'hAAAA_0000);
            end else begin
                drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
            end
            @(negedge clk);
            chk("lat_imem_addr", imem_addr, 32'd0);
            chk("lat_imem_req", {31'd0, imem_req}, 32'd1);
            if (n < 2) chk("lat_inst_valid_wait", {31'd0, inst_valid}, 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lat_next_addr", imem_addr, 32'd4);
        chk("lat_next_valid", {31'd0, inst_valid}, 32'd0);
        next_cycle();

        // Freeze while the ack arrives: word held in HOLD.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hE3A0_1005);
        @(negedge clk);
        chk("frz_ack_pc_out", pc_out, 32'd4);
        next_cycle();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hold_imem_req", {31'd0, imem_req}, 32'd0);
        chk("hold_instruction", instruction_out, 32'hE3A0_1005);
        chk("hold_pc_out", pc_out, 32'd4);
        chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
        expect_word(32'd4, 32'hE3A0_1005);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("unfrz_pc_out", pc_out, 32'd8);
        chk("unfrz_imem_addr", imem_addr, 32'd4);
        next_cycle();

        // Branch while a slow fetch of address 8 is outstanding.
        do_reset();
        for (int n = 0; n < 2; n++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h200 + n);
            expect_word(32'd4 * (n + 1), 32'h200 + n);
            next_cycle();
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("br_fetch_addr", imem_addr, 32'd8);
        next_cycle();
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        chk("br_inst_valid", {31'd0, inst_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("drop_stale_addr", imem_addr, 32'd8);
        chk("drop_imem_req", {31'd0, imem_req}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("drop_ack_valid", {31'd0, inst_valid}, 32'd0);
        chk("drop_ack_inst", instruction_out, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h11);
        expect_word(32'h44, 32'h11);
        @(negedge clk);
        chk("br_target_addr", imem_addr, 32'h40);
        next_cycle();

        // Branch with freeze in HOLD, misaligned target; then PC wrap.
        do_reset();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'h55);
        next_cycle();
        drive(1'b1, 1'b1, 32'h83, 1'b0, 32'h0);
        @(negedge clk);
        chk("hold_br_valid", {31'd0, inst_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hold_br_addr", imem_addr, 32'h80);
        chk("hold_br_req", {31'd0, imem_req}, 32'd1);
        chk("hold_br_pc_out", pc_out, 32'h84);
        next_cycle();
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0BAD);
        @(negedge clk);
        chk("wrap_pc_out", pc_out, 32'd0);
        chk("wrap_drop_addr", imem_addr, 32'h80);
        next_cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h77);
        expect_word(32'd0, 32'h77);
        @(negedge clk);
        chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle();

`ifdef STAGE_IF_PERF_EN
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
            next_cycle();
            drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h300 + n);
            expect_word(32'd4 * (n + 1), 32'h300 + n);
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("perf_fetched", perf_fetched, 32'd5);
        chk("perf_stall", perf_stall, 32'd5);
        next_cycle();
        do_reset();
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_stall_rst", perf_stall, 32'd0);
`endif

        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'h0);
        next_cycle();
        chk("queue_final", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
